// File: rtl/lfsr_checker.sv
// Self-synchronising serial PRBS checker for the 8-bit Fibonacci LFSR stream
// (taps o[7]^o[5]^o[4]^o[3], newest bit in o[7]); locks on a clean run, counts errors while locked.
module lfsr_checker #(
  parameter int SYNC_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i,
  input  logic                 valid,
  input  logic                 clear,
  output logic [7:0]           o,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 zero,
  output logic [1:0]           state_dbg
);

  // Handshake: i is consumed on a rising edge only when valid is high; there is
  // no back-pressure, so every valid bit is accepted on the edge that samples it.

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             fill_q, fill_d;
  logic [7:0]             run_q, run_d;
  logic [7:0]             miss_q, miss_d;
  logic [7:0]             o_d;
  logic [ERR_WIDTH-1:0]   err_d;
  logic                   error_d;
  logic                   pred;
  logic                   mismatch;
  logic [8:0]             run_inc;
  logic [8:0]             miss_inc;

  assign pred     = o[7] ^ o[5] ^ o[4] ^ o[3];
  assign mismatch = i ^ pred;
  assign run_inc  = {1'b0, run_q} + 9'd1;
  assign miss_inc = {1'b0, miss_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    miss_d  = miss_q;
    o_d     = o;
    err_d   = err_count;
    error_d = 1'b0;
    if (valid) begin
      // The received bit is always shifted in, never the prediction.
      o_d = {i, o[7:1]};
      case (state_q)
        ST_FILL: begin
          if (fill_q == 3'd4) begin
            fill_d  = 3'd0;
            state_d = ST_SYNC;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
        ST_SYNC: begin
          if (mismatch) begin
            run_d = 8'd0;
          end else if (run_inc == 9'(SYNC_COUNT)) begin
            run_d   = 8'd0;
            miss_d  = 8'd0;
            state_d = ST_LOCKED;
          end else begin
            run_d = run_inc[7:0];
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            error_d = 1'b1;
            if (err_count != '1) err_d = err_count + ERR_WIDTH'(1);
            if (miss_inc == 9'(LOSS_COUNT)) begin
              miss_d  = 8'd0;
              run_d   = 8'd0;
              state_d = ST_SYNC;
            end else begin
              miss_d = miss_inc[7:0];
            end
          end else begin
            miss_d = 8'd0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
    if (clear) err_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      fill_q    <= 3'd0;
      run_q     <= 8'd0;
      miss_q    <= 8'd0;
      o         <= 8'h00;
      err_count <= '0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      o         <= o_d;
      err_count <= err_d;
      error     <= error_d;
    end
  end

  // The all-zero stream satisfies the recurrence and locks; zero flags that case.
  assign locked    = (state_q == ST_LOCKED);
  assign zero      = locked && (o == 8'h00);
  assign state_dbg = state_q;

endmodule
